// File: rtl/register_file.sv
// Parametrised register bank: one byte-strobed write port, two independent read ports.
// Optional hardwired zero entry, combinational or registered reads, and write-to-read bypass.
module register_file #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 32,
    parameter int ADDR_W    = 5,
    parameter int ZERO_REG  = 1,
    parameter int READ_MODE = 0,
    parameter int BYPASS    = 1
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 WE,
    input  logic [ADDR_W-1:0]    WAddr,
    input  logic [WIDTH/8-1:0]   WStrb,
    input  logic [WIDTH-1:0]     Data,
    input  logic [ADDR_W-1:0]    RAddr1,
    input  logic [ADDR_W-1:0]    RAddr2,
    output logic [WIDTH-1:0]     Dout1,
    output logic [WIDTH-1:0]     Dout2
);

    localparam int NBYTES = WIDTH / 8;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [WIDTH-1:0]  mask;
    logic [WIDTH-1:0]  merged;
    logic              wr_ok;
    logic [ADDR_W-1:0] raddr [2];
    logic [WIDTH-1:0]  rdata [2];

    always_comb begin
        mask = '0;
        for (int i = 0; i < NBYTES; i++) begin
            mask[8*i +: 8] = {8{WStrb[i]}};
        end
    end

    // A write held off by reset, out of range, or aimed at the zero entry never lands or bypasses.
    assign wr_ok  = Rst_n && WE && (32'(WAddr) < DEPTH) && !((ZERO_REG != 0) && (WAddr == '0));
    assign merged = (mem[WAddr] & ~mask) | (Data & mask);

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[WAddr] <= merged;
        end
    end

    assign raddr[0] = RAddr1;
    assign raddr[1] = RAddr2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[p] = '0;
            if ((32'(raddr[p]) < DEPTH) && !((ZERO_REG != 0) && (raddr[p] == '0))) begin
                if ((BYPASS != 0) && wr_ok && (raddr[p] == WAddr)) begin
                    rdata[p] = merged;
                end else begin
                    rdata[p] = mem[raddr[p]];
                end
            end
        end
    end

    // Registered mode samples the same bypass-aware read value at the edge.
    if (READ_MODE != 0) begin : g_read_reg
        always_ff @(posedge Clk) begin
            if (!Rst_n) begin
                Dout1 <= '0;
                Dout2 <= '0;
            end else begin
                Dout1 <= rdata[0];
                Dout2 <= rdata[1];
            end
        end
    end else begin : g_read_comb
        assign Dout1 = rdata[0];
        assign Dout2 = rdata[1];
    end

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: four configurations share one stimulus stream; a reference
// model fills an expected queue at drive time, outputs are popped and compared afterwards.
module tb_register_file;

    typedef struct packed {
        logic        rst;
        logic        w;
        logic [4:0]  wa;
        logic [3:0]  s;
        logic [31:0] d;
        logic [4:0]  a1;
        logic [4:0]  a2;
    } stim_t;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [4:0]  waddr;
    logic [3:0]  wstrb;
    logic [31:0] data;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] c1, c2, n1, n2, r1, r2, q1, q2;

    logic [31:0] m [32];
    logic [31:0] exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // comb read, bypass on
    register_file #(.DEPTH(32), .ZERO_REG(1), .READ_MODE(0), .BYPASS(1)) dut_c (
        .Clk(clk), .Rst_n(rst_n), .WE(we), .WAddr(waddr), .WStrb(wstrb), .Data(data),
        .RAddr1(ra1), .RAddr2(ra2), .Dout1(c1), .Dout2(c2));
    // comb read, bypass off
    register_file #(.DEPTH(32), .ZERO_REG(1), .READ_MODE(0), .BYPASS(0)) dut_n (
        .Clk(clk), .Rst_n(rst_n), .WE(we), .WAddr(waddr), .WStrb(wstrb), .Data(data),
        .RAddr1(ra1), .RAddr2(ra2), .Dout1(n1), .Dout2(n2));
    // registered read, bypass on, 20 entries
    register_file #(.DEPTH(20), .ZERO_REG(1), .READ_MODE(1), .BYPASS(1)) dut_r (
        .Clk(clk), .Rst_n(rst_n), .WE(we), .WAddr(waddr), .WStrb(wstrb), .Data(data),
        .RAddr1(ra1), .RAddr2(ra2), .Dout1(r1), .Dout2(r2));
    // registered read, bypass off, 20 entries
    register_file #(.DEPTH(20), .ZERO_REG(1), .READ_MODE(1), .BYPASS(0)) dut_q (
        .Clk(clk), .Rst_n(rst_n), .WE(we), .WAddr(waddr), .WStrb(wstrb), .Data(data),
        .RAddr1(ra1), .RAddr2(ra2), .Dout1(q1), .Dout2(q2));

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) begin
            if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    // Value a read of address a shows right now, for a bank of the given depth.
    function automatic logic [31:0] exp_rd(input logic [4:0] a, input int depth, input bit byp);
        if (int'(a) >= depth || a == 5'd0) return 32'h0;
        if (byp && rst_n && we && a == waddr) return merge(m[a], data, wstrb);
        return m[a];
    endfunction

    function automatic stim_t mk(input logic rst, input logic w, input logic [4:0] wa,
                                 input logic [3:0] s, input logic [31:0] d,
                                 input logic [4:0] a1, input logic [4:0] a2);
        stim_t t;
        t.rst = rst; t.w = w; t.wa = wa; t.s = s; t.d = d; t.a1 = a1; t.a2 = a2;
        return t;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input stim_t t);
        @(negedge clk);
        rst_n = t.rst; we = t.w; waddr = t.wa; wstrb = t.s; data = t.d;
        ra1 = t.a1; ra2 = t.a2;
        #1;
        exp_q.push_back(exp_rd(ra1, 32, 1'b1));
        exp_q.push_back(exp_rd(ra2, 32, 1'b1));
        exp_q.push_back(exp_rd(ra1, 32, 1'b0));
        exp_q.push_back(exp_rd(ra2, 32, 1'b0));
        exp_q.push_back(rst_n ? exp_rd(ra1, 20, 1'b1) : 32'h0);
        exp_q.push_back(rst_n ? exp_rd(ra2, 20, 1'b1) : 32'h0);
        exp_q.push_back(rst_n ? exp_rd(ra1, 20, 1'b0) : 32'h0);
        exp_q.push_back(rst_n ? exp_rd(ra2, 20, 1'b0) : 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m[i] = 32'h0;
        end else if (we && waddr != 5'd0) begin
            m[waddr] = merge(m[waddr], data, wstrb);
        end
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        stim_t st [$];
        logic [31:0] exp;
        logic [31:0] act [4];
        st.push_back(mk(1, 1, 5'd5, 4'hF, 32'hFFFFFFFF, 5'd5, 5'd5));
        st.push_back(mk(0, 1, 5'd6, 4'hF, 32'h12345678, 5'd5, 5'd6));
        for (int a = 0; a < 32; a++) st.push_back(mk(1, 0, 5'd0, 4'h0, 32'h0, a[4:0], 5'(31 - a)));
        foreach (st[k]) begin
            drive(st[k]);
            act = '{c1, c2, n1, n2};
            for (int i = 0; i < 4; i++) begin
                exp = exp_q.pop_front();
                n_checks++;
                if (act[i] !== exp) begin
                    n_fail++;
                    $display("FAIL reset step%0d comb%0d: got %h expected %h", k, i, act[i], exp);
                end
            end
            tick();
            act = '{r1, r2, q1, q2};
            for (int i = 0; i < 4; i++) begin
                exp = exp_q.pop_front();
                n_checks++;
                if (act[i] !== exp) begin
                    n_fail++;
                    $display("FAIL reset step%0d reg%0d: got %h expected %h", k, i, act[i], exp);
                end
            end
        end
    endtask

    task automatic test_write_hold();
        stim_t st [$];
        logic [31:0] exp;
        logic [31:0] act [4];
        st.push_back(mk(1, 1, 5'd5, 4'hF, 32'hFFFFFFFF, 5'd5, 5'd5));
        for (int j = 0; j < 3; j++) st.push_back(mk(1, 0, 5'd5, 4'hF, 32'hF0F0F0F0, 5'd5, 5'd5));
        foreach (st[k]) begin
            drive(st[k]);
            act = '{c1, c2, n1, n2};
            for (int i = 0; i < 4; i++) begin
                exp = exp_q.pop_front();
                n_checks++;
                if (act[i] !== exp) begin
                    n_fail++;
                    $display("FAIL write_hold step%0d comb%0d: got %h expected %h", k, i, act[i], exp);
                end
            end
            tick();
            act = '{r1, r2, q1, q2};
            for (int i = 0; i < 4; i++) begin
                exp = exp_q.pop_front();
                n_checks++;
                if (act[i] !== exp) begin
                    n_fail++;
                    $display("FAIL write_hold step%0d reg%0d: got %h expected %h", k, i, act[i], exp);
                end
            end
        end
        n_checks++;
        if (c1 !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL write_hold entry5: got %h expected ffffffff", c1);
        end
    endtask

    task automatic test_strobe();
        stim_t st [$];
        logic [31:0] exp;
        logic [31:0] act [4];
        st.push_back(mk(1, 1, 5'd5, 4'b0101, 32'hF0F0F0F0, 5'd5, 5'd4));
        st.push_back(mk(1, 0, 5'd0, 4'h0, 32'h0, 5'd5, 5'd5));
        st.push_back(mk(1, 1, 5'd5, 4'h0, 32'h00000000, 5'd5, 5'd5));
        st.push_back(mk(1, 1, 5'd4, 4'b1000, 32'hAB000000, 5'd4, 5'd5));
        st.push_back(mk(1, 1, 5'd4, 4'b0010, 32'h0000CD00, 5'd4, 5'd4));
        st.push_back(mk(1, 0, 5'd0, 4'h0, 32'h0, 5'd4, 5'd5));
        foreach (st[k]) begin
            drive(st[k]);
            act = '{c1, c2, n1, n2};
            for (int i = 0; i < 4; i++) begin
                exp = exp_q.pop_front();
                n_checks++;
                if (act[i] !== exp) begin
                    n_fail++;
                    $display("FAIL strobe step%0d comb%0d: got %h expected %h", k, i, act[i], exp);
                end
            end
            tick();
            act = '{r1, r2, q1, q2};
            for (int i = 0; i < 4; i++) begin
                exp = exp_q.pop_front();
                n_checks++;
                if (act[i] !== exp) begin
                    n_fail++;
                    $display("FAIL strobe step%0d reg%0d: got %h expected %h", k, i, act[i], exp);
                end
            end
        end
        n_checks++;
        if (c2 !== 32'hFFF0FFF0) begin
            n_fail++;
            $display("FAIL strobe entry5: got %h expected fff0fff0", c2);
        end
    endtask

    task automatic test_ignored();
        stim_t st [$];
        logic [31:0] exp;
        logic [31:0] act [4];
        st.push_back(mk(1, 1, 5'd0, 4'hF, 32'h12345678, 5'd0, 5'd0));
        st.push_back(mk(1, 0, 5'd0, 4'h0, 32'h0, 5'd0, 5'd0));
        st.push_back(mk(1, 1, 5'd25, 4'hF, 32'hDEADBEEF, 5'd25, 5'd25));
        st.push_back(mk(1, 0, 5'd0, 4'h0, 32'h0, 5'd25, 5'd5));
        st.push_back(mk(1, 1, 5'd19, 4'hF, 32'hCAFEF00D, 5'd19, 5'd20));
        st.push_back(mk(1, 1, 5'd20, 4'hF, 32'h01020304, 5'd20, 5'd19));
        st.push_back(mk(1, 0, 5'd0, 4'h0, 32'h0, 5'd20, 5'd19));
        foreach (st[k]) begin
            drive(st[k]);
            act = '{c1, c2, n1, n2};
            for (int i = 0; i < 4; i++) begin
                exp = exp_q.pop_front();
                n_checks++;
                if (act[i] !== exp) begin
                    n_fail++;
                    $display("FAIL ignored step%0d comb%0d: got %h expected %h", k, i, act[i], exp);
                end
            end
            tick();
            act = '{r1, r2, q1, q2};
            for (int i = 0; i < 4; i++) begin
                exp = exp_q.pop_front();
                n_checks++;
                if (act[i] !== exp) begin
                    n_fail++;
                    $display("FAIL ignored step%0d reg%0d: got %h expected %h", k, i, act[i], exp);
                end
            end
        end
    endtask

    task automatic test_read_latency();
        stim_t st [$];
        logic [31:0] exp;
        logic [31:0] act [4];
        st.push_back(mk(1, 1, 5'd7, 4'hF, 32'hA5A5A5A5, 5'd0, 5'd7));
        st.push_back(mk(1, 0, 5'd0, 4'h0, 32'h0, 5'd0, 5'd7));
        foreach (st[k]) begin
            drive(st[k]);
            act = '{c1, c2, n1, n2};
            for (int i = 0; i < 4; i++) begin
                exp = exp_q.pop_front();
                n_checks++;
                if (act[i] !== exp) begin
                    n_fail++;
                    $display("FAIL latency step%0d comb%0d: got %h expected %h", k, i, act[i], exp);
                end
            end
            tick();
            act = '{r1, r2, q1, q2};
            for (int i = 0; i < 4; i++) begin
                exp = exp_q.pop_front();
                n_checks++;
                if (act[i] !== exp) begin
                    n_fail++;
                    $display("FAIL latency step%0d reg%0d: got %h expected %h", k, i, act[i], exp);
                end
            end
        end
    endtask

    task automatic test_same_addr();
        stim_t st [$];
        logic [31:0] exp;
        logic [31:0] act [4];
        st.push_back(mk(1, 1, 5'd3, 4'hF, 32'h0000BEEF, 5'd3, 5'd3));
        st.push_back(mk(1, 0, 5'd0, 4'h0, 32'h0, 5'd3, 5'd3));
        st.push_back(mk(1, 1, 5'd3, 4'b1000, 32'h11111111, 5'd3, 5'd3));
        st.push_back(mk(1, 0, 5'd0, 4'h0, 32'h0, 5'd3, 5'd3));
        foreach (st[k]) begin
            drive(st[k]);
            act = '{c1, c2, n1, n2};
            for (int i = 0; i < 4; i++) begin
                exp = exp_q.pop_front();
                n_checks++;
                if (act[i] !== exp) begin
                    n_fail++;
                    $display("FAIL same_addr step%0d comb%0d: got %h expected %h", k, i, act[i], exp);
                end
            end
            tick();
            act = '{r1, r2, q1, q2};
            for (int i = 0; i < 4; i++) begin
                exp = exp_q.pop_front();
                n_checks++;
                if (act[i] !== exp) begin
                    n_fail++;
                    $display("FAIL same_addr step%0d reg%0d: got %h expected %h", k, i, act[i], exp);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t t;
        logic [31:0] exp;
        logic [31:0] act [4];
        for (int k = 0; k < 60; k++) begin
            t.rst = ($urandom_range(0, 15) != 0);
            t.w   = ($urandom_range(0, 3) != 0);
            t.wa  = 5'($urandom_range(0, 31));
            t.s   = 4'($urandom_range(0, 15));
            t.d   = $urandom;
            t.a1  = ($urandom_range(0, 1) != 0) ? t.wa : 5'($urandom_range(0, 31));
            t.a2  = ($urandom_range(0, 1) != 0) ? t.wa : 5'($urandom_range(0, 31));
            drive(t);
            act = '{c1, c2, n1, n2};
            for (int i = 0; i < 4; i++) begin
                exp = exp_q.pop_front();
                n_checks++;
                if (act[i] !== exp) begin
                    n_fail++;
                    $display("FAIL b2b step%0d comb%0d: got %h expected %h", k, i, act[i], exp);
                end
            end
            tick();
            act = '{r1, r2, q1, q2};
            for (int i = 0; i < 4; i++) begin
                exp = exp_q.pop_front();
                n_checks++;
                if (act[i] !== exp) begin
                    n_fail++;
                    $display("FAIL b2b step%0d reg%0d: got %h expected %h", k, i, act[i], exp);
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n = 1'b0; we = 1'b0; waddr = '0; wstrb = '0; data = '0; ra1 = '0; ra2 = '0;
        tick();
        tick();
        test_reset();
        test_write_hold();
        test_strobe();
        test_ignored();
        test_read_latency();
        test_same_addr();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
